lsu: RTL and testbench
======================

# lsu

Load/store unit between the execute stage and the unified `mem` block's data port. Accepts one load or store request at a time from the pipeline using a valid/ready handshake. Drives `mem`'s synchronous write port and its 2-cycle read port. Returns a sign- or zero-extended load result, or a store completion, as a single-cycle response pulse; misaligned or illegal requests are faulted without touching memory.

## Interface
Parameters:
- `XLEN`, taken from `` `XLEN `` in `macros.hv` (32): data/address width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  pipeline presents a request.
- `req_ready`  out  1  LSU can accept a request; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 (size/signedness).
- `req_addr`  in  XLEN  byte address.
- `req_wdata`  in  XLEN  store data (rs2), LSB-justified.
- `req_rd`  in  5  destination tag, returned unchanged.
- `resp_valid`  out  1  one-cycle response pulse; no backpressure.
- `resp_rdata`  out  XLEN  load result; 0 for stores and faults.
- `resp_rd`  out  5  tag of the request being answered.
- `resp_fault`  out  1  request was misaligned or had an illegal funct3.
- `data_addr_r`  out  XLEN  to `mem` read address.
- `data_r`  in  XLEN  from `mem` read data.
- `data_w_en`, `data_addr_w`, `data_w`, `data_len_w[1:0]`  out  to `mem` write port.
  - `data_len_w`: 0 = byte, 1 = half, 2 = word.

## Operation
- The FSM has five states: IDLE, RD1, RD2, WR, RESP.
- **Handshake.** A request is accepted on a rising edge where `req_valid & req_ready`.
  - On acceptance, `req_we`, `req_funct3`, `req_addr`, `req_wdata` and `req_rd` are latched into `_q` registers.
  - `req_ready` = (state == IDLE).
- **Legal funct3.**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is a fault.
- **Misalignment.** A half access with `addr[0]` = 1 is a fault. A word access with `addr[1:0]` ≠ 0 is a fault.
- **State transitions.**
  - IDLE → RESP when the accepted request faults. No memory access is made in this case.
  - IDLE → RD1 for a legal load.
  - IDLE → WR for a legal store.
  - RD1 → RD2 → RESP.
  - WR → RESP.
  - RESP → IDLE, always.
- **Loads.**
  - `data_addr_r` = `addr_q` in RD1, RD2 and RESP; otherwise 0.
  - In RESP, `resp_rdata` is extracted combinationally from `data_r`, whose byte 0 is at `addr_q`:
    - LB: sign-extend `[7:0]`.
    - LBU: zero-extend `[7:0]`.
    - LH: sign-extend `[15:0]`.
    - LHU: zero-extend `[15:0]`.
    - LW: `[31:0]`.
- **Stores.**
  - In WR: `data_w_en` = 1, `data_addr_w` = `addr_q`, `data_w` = `wdata_q` unshifted, `data_len_w` = `funct3_q[1:0]`.
  - Outside WR, all four write-port outputs are 0.
- **Response.** In RESP: `resp_valid` = 1, `resp_rd` = `rd_q`, `resp_fault` = `fault_q`. `resp_rdata` = 0 for a store or a fault.
- **Reset values** (state = IDLE): `req_ready` = 1; every other output = 0.

## Timing
- Request accepted at edge E0. The cycles after each edge are:
  - Load: RD1 after E0, RD2 after E1, RESP after E2. `resp_valid` is high in the 3rd cycle after acceptance.
  - Store: WR after E0; the memory write commits at E1; RESP after E1.
  - Fault: RESP directly after E0.
- `data_addr_r` is held stable for two full edges (E1, E2) before `data_r` is used, which satisfies `mem`'s 2-cycle read rule.
- Throughput:
  - Load: 1 per 4 cycles.
  - Store: 1 per 3 cycles.
  - Fault: 1 per 2 cycles.
  - A new request can be accepted at the edge after RESP (IDLE cycle).
- `req_valid` held high while `req_ready` is low causes no acceptance, and no state is latched.
- **Reset mid-operation.** If `rst_n` is low at an edge, the state becomes IDLE and every in-flight request is dropped with no `resp_valid`.
  - A WR-state write whose edge coincides with reset still commits, because `mem` has no reset.
- **Reset priority.** `rst_n` low overrides a simultaneous `req_valid`: no acceptance.

## Structure
- `macros.hv` holds:
  - `` `XLEN ``
  - funct3 constants: `LB`/`LH`/`LW`/`LBU`/`LHU`/`SB`/`SH`/`SW`
  - the `data_len_w` encodings
  - the FSM state encodings (3-bit)
- Sub-module `lsu_load_align`: combinational; inputs `funct3` and `data_r`; output the extended result. Shared with any future misaligned-access path.

## Test plan
- **Load timing and sign extension.** Preload word 0x80FF7F01 at 0x100.
  - LB at 0x101 → `resp_rdata` = 0x0000007F, `resp_valid` exactly 3 cycles after acceptance.
  - LB at 0x102 → 0xFFFFFFFF.
  - LBU at 0x102 → 0x000000FF.
- **Halfword and word loads** from the same preload.
  - LH at 0x102 → 0xFFFF80FF.
  - LHU at 0x102 → 0x000080FF.
  - LW at 0x100 → 0x80FF7F01.
  - `resp_rd` echoes tag 5.
- **Stores, then read-back.**
  - SB 0xAA to 0x200, SH 0xBEEF to 0x202, then LW 0x200 → 0xBEEF00AA.
  - `data_w_en` is high for exactly 1 cycle per store, and `data_len_w` = 0, then 1.
- **Faults.**
  - LW at 0x103, SH at 0x201, load funct3 = 011 → `resp_fault` = 1, `resp_rdata` = 0, response the cycle after acceptance.
  - `data_w_en` never rises, and memory at 0x200 is unchanged.
- **Back-to-back requests.** Hold `req_valid` high with a queue of LW, SW, LW.
  - `req_ready` is low during RD1/RD2/WR/RESP.
  - Acceptances fall exactly 4 and 3 cycles apart, and no request is lost or duplicated.
- **Reset mid-operation.**
  - Pull `rst_n` low during RD2 → no `resp_valid`, and `req_ready` = 1 the cycle after reset.
  - The next LW at 0x100 then returns correct data.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request-legality helper for the load/store unit.
package lsu_pkg;

    localparam int LSU_XLEN = 32;

    // RISC-V funct3 encodings for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Write-port access size encodings
    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_RD2  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // A request faults on an unsupported funct3 or on a misaligned half/word address
    function automatic logic req_fault(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic bad_f3;
        logic mis;
        if (we) begin
            bad_f3 = !(f3 inside {F3_SB, F3_SH, F3_SW});
        end else begin
            bad_f3 = !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        end
        mis = ((f3[1:0] == LEN_HALF) && a[0]) || ((f3[1:0] == LEN_WORD) && (a != 2'b00));
        return bad_f3 || mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-result extraction: picks byte/half/word from the read data and extends it.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] data_r,
    output logic [XLEN-1:0] rdata
);

    logic signed [7:0]      byte_s;
    logic signed [15:0]     half_s;
    logic signed [XLEN-1:0] byte_ext;
    logic signed [XLEN-1:0] half_ext;

    assign byte_s   = data_r[7:0];
    assign half_s   = data_r[15:0];
    assign byte_ext = XLEN'(byte_s);
    assign half_ext = XLEN'(half_s);

    // Select the access size and extension mode from funct3
    always_comb begin
        rdata = '0;
        case (funct3)
            F3_LB:   rdata = byte_ext;
            F3_LH:   rdata = half_ext;
            F3_LW:   rdata = data_r;
            F3_LBU:  rdata = {{(XLEN-8){1'b0}}, data_r[7:0]};
            F3_LHU:  rdata = {{(XLEN-16){1'b0}}, data_r[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, 2-cycle reads, single-cycle writes, faults bypass memory.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic [4:0]      resp_rd,
    output logic            resp_fault,
    output logic [XLEN-1:0] data_addr_r,
    input  logic [XLEN-1:0] data_r,
    output logic            data_w_en,
    output logic [XLEN-1:0] data_addr_w,
    output logic [XLEN-1:0] data_w,
    output logic [1:0]      data_len_w
);

    state_t          state;
    state_t          state_nxt;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [4:0]      rd_q;
    logic            fault_q;
    logic            accept;
    logic            req_flt;
    logic [XLEN-1:0] load_data;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign req_flt   = req_fault(req_we, req_funct3, req_addr[1:0]);

    // State register; reset returns to IDLE and drops any in-flight request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the accepted request; data fields need no reset, and reset blocks acceptance
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rd_q     <= req_rd;
            fault_q  <= req_flt;
        end
    end

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .funct3 (funct3_q),
        .data_r (data_r),
        .rdata  (load_data)
    );

    // Next-state selection and per-state drive of the memory ports and response
    always_comb begin
        state_nxt   = state;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        resp_rd     = '0;
        resp_fault  = 1'b0;
        data_addr_r = '0;
        data_w_en   = 1'b0;
        data_addr_w = '0;
        data_w      = '0;
        data_len_w  = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_flt) begin
                        state_nxt = ST_RESP;
                    end else if (req_we) begin
                        state_nxt = ST_WR;
                    end else begin
                        state_nxt = ST_RD1;
                    end
                end
            end
            ST_RD1: begin
                data_addr_r = addr_q;
                state_nxt   = ST_RD2;
            end
            ST_RD2: begin
                data_addr_r = addr_q;
                state_nxt   = ST_RESP;
            end
            ST_WR: begin
                data_w_en   = 1'b1;
                data_addr_w = addr_q;
                data_w      = wdata_q;
                data_len_w  = funct3_q[1:0];
                state_nxt   = ST_RESP;
            end
            ST_RESP: begin
                data_addr_r = addr_q;
                resp_valid  = 1'b1;
                resp_rd     = rd_q;
                resp_fault  = fault_q;
                if (!we_q && !fault_q) begin
                    resp_rdata = load_data;
                end
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: memory model on the data port, reference model of the ISA rules.
module tb_lsu;
    import lsu_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [2:0]      req_funct3 = '0;
    logic [XLEN-1:0] req_addr = '0;
    logic [XLEN-1:0] req_wdata = '0;
    logic [4:0]      req_rd = '0;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic [4:0]      resp_rd;
    logic            resp_fault;
    logic [XLEN-1:0] data_addr_r;
    logic [XLEN-1:0] data_r;
    logic            data_w_en;
    logic [XLEN-1:0] data_addr_w;
    logic [XLEN-1:0] data_w;
    logic [1:0]      data_len_w;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    lsu #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_rd     (resp_rd),
        .resp_fault  (resp_fault),
        .data_addr_r (data_addr_r),
        .data_r      (data_r),
        .data_w_en   (data_w_en),
        .data_addr_w (data_addr_w),
        .data_w      (data_w),
        .data_len_w  (data_len_w)
    );

    // Memory on the DUT's data port: synchronous write, two-edge read latency, no reset
    logic [7:0]  mem [0:4095];
    logic        mem_init = 1'b0;
    logic [31:0] rd_s1 = '0;
    logic [31:0] rd_s2 = '0;
    assign data_r = rd_s2;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [11:0] b;
        b = a[11:0];
        return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
    endfunction

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem_init <= 1'b1;
        end else if (data_w_en) begin
            for (int k = 0; k < 4; k++) begin
                if (k < (1 << data_len_w)) mem[data_addr_w[11:0] + 12'(k)] <= data_w[8*k +: 8];
            end
        end
        rd_s1 <= mem_word(data_addr_r);
        rd_s2 <= rd_s1;
    end

    // Reference memory, updated by the model when a store is issued
    byte unsigned ref_mem [0:4095];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Architectural outcome of one request: fault, load value, cycles to response
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic flt, output logic [31:0] rdata,
                         output int lat);
        int     nbytes;
        bit     legal;
        longint val;
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (f3[1:0] == 2'd3) legal = 1'b0;
        flt   = !legal || ((addr % nbytes) != 0);
        rdata = 32'h0;
        if (flt) begin
            lat = 1;
        end else if (we) begin
            lat = 2;
            for (int k = 0; k < nbytes; k++) ref_mem[(addr + k) % 4096] = byte'(wdata >> (8 * k));
        end else begin
            lat = 3;
            val = 0;
            for (int k = 0; k < nbytes; k++) val = val + (longint'(ref_mem[(addr + k) % 4096]) << (8 * k));
            if (!f3[2] && nbytes < 4 && val >= (longint'(1) << (8 * nbytes - 1)))
                val = val - (longint'(1) << (8 * nbytes));
            rdata = 32'(val);
        end
    endtask

    // Issue one request from an IDLE negedge and check the whole transaction
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd, input string tag,
                           output logic [31:0] got);
        logic        eflt;
        logic [31:0] erd;
        int          elat;
        int          n;
        int          wen_cnt;
        logic [1:0]  len_seen;
        model(we, f3, addr, wdata, eflt, erd, elat);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        n = 1; wen_cnt = 0; len_seen = 2'd3;
        while (!resp_valid && n < 8) begin
            if (data_w_en) begin
                wen_cnt++;
                len_seen = data_len_w;
                chk({tag, ".waddr"}, data_addr_w, addr);
                chk({tag, ".wdata"}, data_w, wdata);
            end
            chk({tag, ".busy"}, 32'(req_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        got = resp_rdata;
        chk({tag, ".lat"}, 32'(n), 32'(elat));
        chk({tag, ".fault"}, 32'(resp_fault), 32'(eflt));
        chk({tag, ".rdata"}, resp_rdata, erd);
        chk({tag, ".rd"}, 32'(resp_rd), 32'(rd));
        if (we && !eflt) begin
            chk({tag, ".wen"}, 32'(wen_cnt), 32'd1);
            chk({tag, ".len"}, 32'(len_seen), 32'(f3[1:0]));
        end else begin
            chk({tag, ".nowen"}, 32'(wen_cnt), 32'd0);
        end
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(resp_valid), 32'd0);
    endtask

    logic [31:0] got;
    logic [2:0]  lf3 [0:4];
    logic [2:0]  sf3 [0:2];

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        lf3[0] = F3_LB; lf3[1] = F3_LH; lf3[2] = F3_LW; lf3[3] = F3_LBU; lf3[4] = F3_LHU;
        sf3[0] = F3_SB; sf3[1] = F3_SH; sf3[2] = F3_SW;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.wen", 32'(data_w_en), 32'd0);
        chk("rst.addr_r", data_addr_r, 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload and sign-extension loads
        run_req(1'b1, F3_SW, 32'h100, 32'h80FF7F01, 5'd1, "pre_sw", got);
        run_req(1'b0, F3_LB,  32'h101, 32'h0, 5'd5, "lb101", got);  chk("lb101.k", got, 32'h0000007F);
        run_req(1'b0, F3_LB,  32'h102, 32'h0, 5'd5, "lb102", got);  chk("lb102.k", got, 32'hFFFFFFFF);
        run_req(1'b0, F3_LBU, 32'h102, 32'h0, 5'd5, "lbu102", got); chk("lbu102.k", got, 32'h000000FF);
        run_req(1'b0, F3_LH,  32'h102, 32'h0, 5'd5, "lh102", got);  chk("lh102.k", got, 32'hFFFF80FF);
        run_req(1'b0, F3_LHU, 32'h102, 32'h0, 5'd5, "lhu102", got); chk("lhu102.k", got, 32'h000080FF);
        run_req(1'b0, F3_LW,  32'h100, 32'h0, 5'd5, "lw100", got);  chk("lw100.k", got, 32'h80FF7F01);

        // Stores then read-back
        run_req(1'b1, F3_SB, 32'h200, 32'h123456AA, 5'd7, "sb200", got);
        run_req(1'b1, F3_SH, 32'h202, 32'h9876BEEF, 5'd8, "sh202", got);
        run_req(1'b0, F3_LW, 32'h200, 32'h0, 5'd9, "lw200", got); chk("lw200.k", got, 32'hBEEF00AA);

        // Faults
        run_req(1'b0, F3_LW, 32'h103, 32'h0, 5'd10, "f_lw103", got);
        run_req(1'b1, F3_SH, 32'h201, 32'hFFFFFFFF, 5'd11, "f_sh201", got);
        run_req(1'b0, 3'b011, 32'h100, 32'h0, 5'd12, "f_ld011", got);
        run_req(1'b1, 3'b100, 32'h200, 32'hFFFFFFFF, 5'd13, "f_st100", got);
        run_req(1'b0, F3_LW, 32'h200, 32'h0, 5'd14, "lw200b", got); chk("lw200b.k", got, 32'hBEEF00AA);

        // Back-to-back with valid held high: LW, SW, LW
        begin
            logic        bwe [0:2];
            logic [2:0]  bf3 [0:2];
            logic [31:0] badr [0:2];
            logic [31:0] bwd [0:2];
            logic [31:0] berd [0:2];
            logic        beflt;
            int          belat;
            int          acc_cyc [0:2];
            int          idx, cyc, nresp, ready_hi;
            logic        acc;
            bwe[0] = 1'b0; bf3[0] = F3_LW; badr[0] = 32'h100; bwd[0] = 32'h0;
            bwe[1] = 1'b1; bf3[1] = F3_SW; badr[1] = 32'h204; bwd[1] = 32'h13572468;
            bwe[2] = 1'b0; bf3[2] = F3_LW; badr[2] = 32'h204; bwd[2] = 32'h0;
            for (int i = 0; i < 3; i++) model(bwe[i], bf3[i], badr[i], bwd[i], beflt, berd[i], belat);
            idx = 0; cyc = 0; nresp = 0; ready_hi = 0;
            for (int i = 0; i < 3; i++) acc_cyc[i] = -100;
            while (nresp < 3 && cyc < 40) begin
                if (idx < 3) begin
                    req_valid = 1'b1; req_we = bwe[idx]; req_funct3 = bf3[idx];
                    req_addr = badr[idx]; req_wdata = bwd[idx]; req_rd = 5'(20 + idx);
                end else begin
                    req_valid = 1'b0;
                end
                #1;
                acc = req_valid && req_ready;
                if (req_ready) ready_hi++;
                if (resp_valid) begin
                    chk("b2b.rdata", resp_rdata, berd[nresp]);
                    chk("b2b.rd", 32'(resp_rd), 32'(20 + nresp));
                    nresp++;
                end
                @(posedge clk);
                if (acc) begin
                    acc_cyc[idx] = cyc;
                    idx++;
                end
                @(negedge clk);
                cyc++;
            end
            req_valid = 1'b0;
            chk("b2b.nresp", 32'(nresp), 32'd3);
            chk("b2b.nacc", 32'(idx), 32'd3);
            chk("b2b.ready_hi", 32'(ready_hi), 32'd3);
            chk("b2b.gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
            chk("b2b.gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
            @(negedge clk);
        end

        // Reset mid-load (in RD2), then reset overriding a request
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h100; req_rd = 5'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid.resp_valid", 32'(resp_valid), 32'd0);
        chk("rstmid.ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW; req_addr = 32'h300; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b1;
        chk("rstpri.ready", 32'(req_ready), 32'd1);
        chk("rstpri.wen", 32'(data_w_en), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rstmid.quiet", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        run_req(1'b0, F3_LW, 32'h100, 32'h0, 5'd4, "lw_after_rst", got);
        chk("lw_after_rst.k", got, 32'h80FF7F01);
        run_req(1'b0, F3_LW, 32'h300, 32'h0, 5'd4, "lw300", got);

        // Randomized mix, mostly legal funct3, addresses in a small window
        for (int t = 0; t < 80; t++) begin
            logic        rwe;
            logic [2:0]  rf3;
            logic [31:0] radr;
            rwe  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) rf3 = 3'($urandom_range(0, 7));
            else if (rwe)                  rf3 = sf3[$urandom_range(0, 2)];
            else                           rf3 = lf3[$urandom_range(0, 4)];
            radr = 32'h300 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 2) != 0) begin
                if (rf3[1:0] == 2'd1) radr[0] = 1'b0;
                if (rf3[1:0] == 2'd2) radr[1:0] = 2'b00;
            end
            run_req(rwe, rf3, radr, $urandom, 5'($urandom_range(0, 31)), "rnd", got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
